// File: rtl/pooling_pkg.sv
// Shared types and elaboration helpers for the pooling window controller.
package pooling_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_EMIT = 2'd2
  } pool_state_e;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int unsigned logb2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Port width for an index range of v values; never zero.
  function automatic int unsigned width_of(input int unsigned v);
    return (logb2(v) == 0) ? 1 : logb2(v);
  endfunction

  function automatic int unsigned pool_out(input int unsigned in_size, input int unsigned k);
    return in_size / k;
  endfunction

endpackage

// File: rtl/pooling_window_ctrl_if.sv
// Row/compare/pooled-row handshake bundle; pool_mode/avg_shift exist only with POOL_AVG_EN.
interface pooling_window_ctrl_if #(
  parameter int unsigned INPUT_SIZE    = 6,
  parameter int unsigned KERNEL_SIZE   = 2,
  parameter int unsigned TOTAL_FEATURE = 4
);
  import pooling_pkg::*;

  localparam int unsigned SEL_W  = width_of(KERNEL_SIZE);
  localparam int unsigned ROW_W  = width_of(pool_out(INPUT_SIZE, KERNEL_SIZE));
  localparam int unsigned FEAT_W = width_of(TOTAL_FEATURE);

  logic              in_valid;
  logic              in_ready;
  logic              cmp_en;
  logic [SEL_W-1:0]  cmp_sel;
  logic              win_first;
  logic              out_valid;
  logic              out_ready;
  logic [ROW_W-1:0]  out_row;
  logic [FEAT_W-1:0] out_feature;
  logic              frame_done;
`ifdef POOL_AVG_EN
  logic              pool_mode;
  logic [7:0]        avg_shift;

  modport master (
    output in_valid, out_ready, pool_mode,
    input  in_ready, cmp_en, cmp_sel, win_first, out_valid, out_row, out_feature,
           frame_done, avg_shift
  );
  modport slave (
    input  in_valid, out_ready, pool_mode,
    output in_ready, cmp_en, cmp_sel, win_first, out_valid, out_row, out_feature,
           frame_done, avg_shift
  );
`else
  modport master (
    output in_valid, out_ready,
    input  in_ready, cmp_en, cmp_sel, win_first, out_valid, out_row, out_feature,
           frame_done
  );
  modport slave (
    input  in_valid, out_ready,
    output in_ready, cmp_en, cmp_sel, win_first, out_valid, out_row, out_feature,
           frame_done
  );
`endif

endinterface

// File: rtl/pool_idx_counter.sv
// Tracks input row, window row, pooled row and feature index across a frame.
module pool_idx_counter
  import pooling_pkg::*;
#(
  parameter  int unsigned INPUT_SIZE    = 6,
  parameter  int unsigned KERNEL_SIZE   = 2,
  parameter  int unsigned TOTAL_FEATURE = 4,
  localparam int unsigned SEL_W         = width_of(KERNEL_SIZE),
  localparam int unsigned ROW_W         = width_of(pool_out(INPUT_SIZE, KERNEL_SIZE)),
  localparam int unsigned FEAT_W        = width_of(TOTAL_FEATURE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_adv,
`ifdef POOL_AVG_EN
  output logic              o_row_first,
`endif
  output logic [SEL_W-1:0]  o_win,
  output logic [ROW_W-1:0]  o_prow,
  output logic [FEAT_W-1:0] o_feature,
  output logic              o_remainder,
  output logic              o_frame_last
);

  localparam int unsigned IN_W = width_of(INPUT_SIZE);
  localparam int unsigned USED = pool_out(INPUT_SIZE, KERNEL_SIZE) * KERNEL_SIZE;

  localparam logic [IN_W-1:0]   ROW_LAST  = IN_W'(INPUT_SIZE - 1);
  localparam logic [IN_W:0]     USED_ROWS = (IN_W + 1)'(USED);
  localparam logic [SEL_W-1:0]  WIN_LAST  = SEL_W'(KERNEL_SIZE - 1);
  localparam logic [ROW_W-1:0]  PROW_LAST = ROW_W'(pool_out(INPUT_SIZE, KERNEL_SIZE) - 1);
  localparam logic [FEAT_W-1:0] FEAT_LAST = FEAT_W'(TOTAL_FEATURE - 1);

  logic [IN_W-1:0]   r_row;
  logic [SEL_W-1:0]  r_win;
  logic [ROW_W-1:0]  r_prow;
  logic [FEAT_W-1:0] r_feature;

  // Pooled row saturates in the remainder region; remainder rows never reach CMP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row     <= '0;
      r_win     <= '0;
      r_prow    <= '0;
      r_feature <= '0;
    end else if (i_adv) begin
      if (r_row == ROW_LAST) begin
        r_row     <= '0;
        r_win     <= '0;
        r_prow    <= '0;
        r_feature <= (r_feature == FEAT_LAST) ? '0 : r_feature + 1'b1;
      end else begin
        r_row <= r_row + 1'b1;
        if (r_win == WIN_LAST) begin
          r_win <= '0;
          if (r_prow != PROW_LAST) r_prow <= r_prow + 1'b1;
        end else begin
          r_win <= r_win + 1'b1;
        end
      end
    end
  end

  assign o_win        = r_win;
  assign o_prow       = r_prow;
  assign o_feature    = r_feature;
  assign o_remainder  = ({1'b0, r_row} >= USED_ROWS);
  assign o_frame_last = (r_row == ROW_LAST) && (r_feature == FEAT_LAST);
`ifdef POOL_AVG_EN
  assign o_row_first  = (r_row == '0);
`endif

endmodule

// File: rtl/pooling_window_ctrl.sv
// Non-overlapping pooling window sequencer: row accept, K compare cycles, pooled-row emit.
// Optional average mode enabled by defining POOL_AVG_EN.
module pooling_window_ctrl
  import pooling_pkg::*;
#(
  parameter int unsigned INPUT_SIZE    = 6,
  parameter int unsigned KERNEL_SIZE   = 2,
  parameter int unsigned TOTAL_FEATURE = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  pooling_window_ctrl_if.slave bus
);

  localparam int unsigned SEL_W  = width_of(KERNEL_SIZE);
  localparam int unsigned ROW_W  = width_of(pool_out(INPUT_SIZE, KERNEL_SIZE));
  localparam int unsigned FEAT_W = width_of(TOTAL_FEATURE);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(KERNEL_SIZE - 1);

  pool_state_e       r_state;
  logic [SEL_W-1:0]  r_sel;
  logic              r_win_first;
  logic              r_last_win;
  logic              r_frame_last;
  logic              r_frame_done;
  logic [ROW_W-1:0]  r_out_row;
  logic [FEAT_W-1:0] r_out_feature;

  logic              w_accept;
  logic [SEL_W-1:0]  w_win;
  logic [ROW_W-1:0]  w_prow;
  logic [FEAT_W-1:0] w_feature;
  logic              w_remainder;
  logic              w_frame_last;

  assign w_accept = bus.in_valid && (r_state == ST_IDLE);

`ifdef POOL_AVG_EN
  localparam logic [7:0] AVG_SHIFT = 8'(2 * logb2(KERNEL_SIZE));
  logic w_row_first;
  logic r_avg_mode;

  if ((KERNEL_SIZE & (KERNEL_SIZE - 1)) != 0) begin : g_kernel_pow2
    $error("pooling_window_ctrl: KERNEL_SIZE must be a power of two for average pooling");
  end
`endif

  pool_idx_counter #(
    .INPUT_SIZE   (INPUT_SIZE),
    .KERNEL_SIZE  (KERNEL_SIZE),
    .TOTAL_FEATURE(TOTAL_FEATURE)
  ) u_idx (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_adv       (w_accept),
`ifdef POOL_AVG_EN
    .o_row_first (w_row_first),
`endif
    .o_win       (w_win),
    .o_prow      (w_prow),
    .o_feature   (w_feature),
    .o_remainder (w_remainder),
    .o_frame_last(w_frame_last)
  );

  // Frame end is flagged either after the last EMIT handshake or, when the
  // final input row is a dropped remainder row, right after that row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_sel         <= '0;
      r_win_first   <= 1'b0;
      r_last_win    <= 1'b0;
      r_frame_last  <= 1'b0;
      r_frame_done  <= 1'b0;
      r_out_row     <= '0;
      r_out_feature <= '0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_remainder) begin
              r_frame_done <= w_frame_last;
            end else begin
              r_state       <= ST_CMP;
              r_sel         <= '0;
              r_win_first   <= (w_win == '0);
              r_last_win    <= (w_win == SEL_LAST);
              r_frame_last  <= w_frame_last;
              r_out_row     <= w_prow;
              r_out_feature <= w_feature;
            end
          end
        end
        ST_CMP: begin
          if (r_sel == SEL_LAST) r_state <= r_last_win ? ST_EMIT : ST_IDLE;
          else                   r_sel   <= r_sel + 1'b1;
        end
        ST_EMIT: begin
          if (bus.out_ready) begin
            r_state      <= ST_IDLE;
            r_frame_done <= r_frame_last;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef POOL_AVG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_avg_mode <= 1'b0;
    else if (w_accept && w_row_first && (w_feature == '0)) r_avg_mode <= bus.pool_mode;
  end

  assign bus.avg_shift = ((r_state == ST_EMIT) && r_avg_mode) ? AVG_SHIFT : '0;
`endif

  assign bus.in_ready    = (r_state == ST_IDLE);
  assign bus.cmp_en      = (r_state == ST_CMP);
  assign bus.cmp_sel     = (r_state == ST_CMP) ? r_sel : '0;
  assign bus.win_first   = (r_state == ST_CMP) && r_win_first;
  assign bus.out_valid   = (r_state == ST_EMIT);
  assign bus.out_row     = r_out_row;
  assign bus.out_feature = r_out_feature;
  assign bus.frame_done  = r_frame_done;

endmodule
